// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter with line filtering, ack check and timeout
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit
);
    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, BITS, ACK, WAITIDLE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_s_q, dat_s_q;
    logic [3:0]    clk_h_q, dat_h_q;
    logic          clk_f_q, dat_f_q, clk_p_q;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic          bit_q, bit_d;
    logic          nack_q, nack_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall, last_inh, timeout;

    // Synchronize both lines, then let the filtered level move only on 4 agreeing samples
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            clk_s_q <= 2'b11;
            dat_s_q <= 2'b11;
            clk_h_q <= 4'hF;
            dat_h_q <= 4'hF;
            clk_f_q <= 1'b1;
            dat_f_q <= 1'b1;
            clk_p_q <= 1'b1;
        end else begin
            clk_s_q <= {clk_s_q[0], ps2_clk_i};
            dat_s_q <= {dat_s_q[0], ps2_data_i};
            clk_h_q <= {clk_h_q[2:0], clk_s_q[1]};
            dat_h_q <= {dat_h_q[2:0], dat_s_q[1]};
            clk_f_q <= (&clk_h_q) ? 1'b1 : (~|clk_h_q) ? 1'b0 : clk_f_q;
            dat_f_q <= (&dat_h_q) ? 1'b1 : (~|dat_h_q) ? 1'b0 : dat_f_q;
            clk_p_q <= clk_f_q;
        end
    end

    assign fall     = clk_p_q & ~clk_f_q;
    assign last_inh = cnt_q == CW'(INHIBIT_CYCLES - 1);
    assign timeout  = cnt_q == CW'(TIMEOUT_CYCLES - 1);

    // Frame state and datapath registers
    always_ff @(posedge clk25) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            par_q    <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            bit_q    <= 1'b1;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_q    <= par_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            bit_q    <= bit_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; the shared counter times the inhibit phase, then the whole frame
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_d    = par_q;
        cnt_d    = cnt_q + CW'(1);
        bitcnt_d = bitcnt_q;
        bit_d    = bit_q;
        nack_d   = nack_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (tx_start && !done_q) begin
                    data_d   = tx_data;
                    par_d    = ~^tx_data;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    nack_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (last_inh) begin
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end
            default: begin
                if (timeout) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (state_q == RTS && fall) begin
                    bit_d    = data_q[0];
                    bitcnt_d = 4'd1;
                    state_d  = BITS;
                end else if (state_q == BITS && fall) begin
                    bit_d    = (bitcnt_q == 4'd9) ? 1'b1 : (bitcnt_q == 4'd8) ? par_q : data_q[bitcnt_q[2:0]];
                    bitcnt_d = bitcnt_q + 4'd1;
                    state_d  = (bitcnt_q == 4'd10) ? ACK : BITS;
                end else if (state_q == ACK) begin
                    nack_d  = dat_f_q;
                    state_d = WAITIDLE;
                end else if (state_q == WAITIDLE && clk_f_q && dat_f_q) begin
                    done_d  = 1'b1;
                    err_d   = nack_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign ps2_clk_oe  = state_q == INHIBIT;
    assign ps2_data_oe = (state_q == INHIBIT && last_inh) || state_q == RTS || (state_q == BITS && !bit_q);
    assign tx_busy     = state_q != IDLE;
    assign rx_inhibit  = tx_busy;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2500, clock-low hold before request-to-send (100 us at 25 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 375000, maximum frame duration after clock release (15 ms at 25 MHz).
REQ-003 SHALL have port clk25 input 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n input 1: reset, synchronous, active-low.
REQ-005 SHALL have port ps2_clk_i input 1: raw PS/2 clock line level, asynchronous.
REQ-006 SHALL have port ps2_data_i input 1: raw PS/2 data line level, asynchronous.
REQ-007 SHALL have port ps2_clk_oe output 1: 1 = drive PS/2 clock low; 0 = release.
REQ-008 SHALL have port ps2_data_oe output 1: 1 = drive PS/2 data low; 0 = release.
REQ-009 SHALL have port tx_data input 8: command byte to send to the keyboard.
REQ-010 SHALL have port tx_start input 1: one-cycle request; tx_data is sampled in the same cycle.
REQ-011 SHALL have port tx_busy output 1: frame in progress.
REQ-012 SHALL have port tx_done output 1: one-cycle pulse at the end of a frame.
REQ-013 SHALL have port tx_err output 1: valid with tx_done; 1 = NACK or timeout.
REQ-014 SHALL have port rx_inhibit output 1: equals tx_busy; tells the keyboard receiver to ignore line activity.

Function
REQ-015 SHALL pass each line through a 2-flop synchronizer, then a filter that changes state only after 4 consecutive equal samples.
REQ-016 SHALL define a falling edge (fall) as the filtered clock going 1->0; fall is asserted for exactly one cycle.
REQ-017 SHALL implement states IDLE, INHIBIT, RTS, BITS, ACK, WAITIDLE.
REQ-018 IDLE: on tx_start=1, latch tx_data, compute odd parity P = ~^tx_data, clear the counters, set tx_busy=1 and go to INHIBIT next cycle.
REQ-019 INHIBIT: ps2_clk_oe=1 for INHIBIT_CYCLES cycles; in the last of these cycles also set ps2_data_oe=1; then go to RTS.
REQ-020 RTS: ps2_clk_oe=0, ps2_data_oe=1 (start bit), start the timeout counter; on the first fall, drive data bit 0 and go to BITS with bitcnt=1.
REQ-021 BITS: on each fall, output by bitcnt: 1..7 -> data bits 1..7, 8 -> P, 9 -> release data (stop); increment bitcnt; ps2_data_oe = ~bit.
REQ-022 BITS: on the fall with bitcnt=10, go to ACK.
REQ-023 ACK: sample filtered data in the cycle after the ack fall; low = ACK (err=0), high = NACK (err=1); go to WAITIDLE.
REQ-024 WAITIDLE: wait until filtered clock=1 and data=1, then pulse tx_done with the latched err, clear tx_busy, go to IDLE.
REQ-025 SHALL release both lines (oe=0) in all states except INHIBIT, RTS and BITS.
REQ-026 Timeout: if the counter reaches TIMEOUT_CYCLES in RTS, BITS, ACK or WAITIDLE, release both lines, pulse tx_done with tx_err=1, and go to IDLE; a timeout has priority over a simultaneous fall.
REQ-027 SHALL ignore tx_start while tx_busy=1; tx_data changes during a frame SHALL have no effect.
REQ-028 tx_start in the same cycle as tx_done SHALL be ignored; a new request is accepted from the following cycle.
REQ-029 tx_err SHALL hold its value until the next accepted tx_start, which clears it.

Reset
REQ-030 reset_n=0 at a clock edge SHALL force IDLE with ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, rx_inhibit=0, counters=0, and synchronizer/filter outputs=1.
REQ-031 Reset mid-frame SHALL release both lines on the next edge and produce no tx_done pulse.

Verification
REQ-032 tx_data=0xED with a device model clocking at 12.5 kHz -> clock held low 2500 cycles; bits 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK -> tx_done=1, tx_err=0.
REQ-033 tx_data=0x01 -> parity bit 0 on the line; tx_data=0x00 -> parity bit 1; both complete with tx_err=0.
REQ-034 Device leaves data high at the ack clock -> tx_done with tx_err=1; both lines released; tx_busy=0.
REQ-035 Device never clocks after RTS -> exactly 375000 cycles after clock release, tx_done=1, tx_err=1, ps2_data_oe=0.
REQ-036 tx_start=1 with tx_data=0xFF at bit 4 of a 0xED frame -> the frame on the line is unchanged; no second frame follows.
REQ-037 reset_n=0 for 1 cycle during BITS -> oe outputs 0 next cycle, no tx_done; a following 0xF4 request transmits correctly.
